lmi_cbus_arb: RTL and testbench
===============================

Name: lmi_cbus_arb

Overview:
- Arbitrates the core's instruction-side (CBUS_I*) and data-side (CBUS_D*) cache-bus requests onto one shared external memory port (MEM_*).
- Sits between the local bus controller and the system memory interface.
- Owns a 1-entry posted write buffer and drives the write-buffer-empty status.
- Sequences single-word and line-fill read bursts, and routes returned beats back to the requesting side.

Parameters:
- LINE_WORDS, 4, beats per line fill; power of two, 2..8.
- BCNT_W, 3, beat counter width; must satisfy 2^BCNT_W >= LINE_WORDS.

Ports:
- IDCLOCKI  in  1  system clock, all state on rising edge
- RESET_D2_R_N  in  1  asynchronous active-low reset
- CBUS_IREQ  in  1  single-cycle instruction fetch request pulse
- CBUS_IADDR  in  32  fetch address
- CBUS_IUC  in  1  1 = uncached single word; 0 = line fill
- CBUS_DREQ  in  1  single-cycle data request pulse
- CBUS_DADDR  in  32  data address
- CBUS_DRW  in  1  1 = write, 0 = read
- CBUS_DLINE  in  1  read is a line fill
- CBUS_DBE  in  4  byte enables
- CBUS_DO  in  32  write data; valid in the CBUS_DREQ cycle
- CBUS_SIVAL  out  1  instruction beat valid
- CBUS_SIDATA  out  32  instruction beat data
- CBUS_SDVAL  out  1  data read beat valid
- CBUS_SDDATA  out  32  data read beat data
- CBUS_SWBEMPTY  out  1  write buffer empty
- ARB_OVF  out  1  sticky: request arrived while same-class slot busy
- MEM_REQ  out  1  memory request, held until MEM_ACK
- MEM_ADDR  out  32  request address
- MEM_WR  out  1  write
- MEM_BURST  out  1  line fill of LINE_WORDS beats
- MEM_BE  out  4  byte enables; 4'hF for reads
- MEM_WDATA  out  32  write data
- MEM_ACK  in  1  request accepted this cycle
- MEM_RVAL  in  1  read beat valid
- MEM_RDATA  in  32  read beat data

Behaviour:
- Reset (async, RESET_D2_R_N low): CBUS_SWBEMPTY=1; every other output 0; all pending slots and counters cleared, state IDLE. Reset mid-transaction abandons it; MEM_RVAL beats after reset release are ignored in IDLE.

Capture:
- Three slots: I_PEND, DR_PEND, WB (write buffer).
- A request pulse at cycle t loads its slot at the t edge. The earliest MEM_REQ is at t+1.
- CBUS_IREQ and CBUS_DREQ in the same cycle: both are captured.
- A pulse for an occupied slot is dropped and ARB_OVF is set. ARB_OVF clears only on reset.
- A write sets WB and drops CBUS_SWBEMPTY at t+1. CBUS_SWBEMPTY rises the cycle after the write's MEM_ACK.

Arbitration (in IDLE):
- Eligible set is I_PEND, WB, and DR_PEND only if WB is empty. A pending write always precedes any data read, which preserves RAW ordering.
- D-side (WB or DR) versus I: round-robin on LAST_D. The side not granted last wins; LAST_D resets to 0, so D wins the first contest.
- WB takes precedence over DR within the D side.

States:
- IDLE -> REQ on a grant. MEM_* fields come from the granted slot; reads force MEM_ADDR[1:0]=0.
- REQ: MEM_REQ held high with stable fields until MEM_ACK.
  - Write ack: clear WB, go to IDLE.
  - Read ack: go to RDATA with BCNT=0.
- RDATA: count MEM_RVAL beats.
  - Each beat is registered and returned the next cycle: CBUS_SIVAL/SIDATA for an I grant, CBUS_SDVAL/SDDATA for a D read.
  - Number of beats = LINE_WORDS for a burst, else 1.
  - On the last beat, clear the slot and go to IDLE. The next MEM_REQ can assert in the cycle after the last beat.
  - MEM_RVAL together with MEM_ACK is not legal; beats are counted only in RDATA.
- Burst: I when !CBUS_IUC; D read when CBUS_DLINE. Beat wrap order is the memory's concern; the arbiter does no address increment.

Latency:
- Idle bus, MEM_ACK immediate, first RVAL one cycle after ACK: DREQ at t -> MEM_REQ t+1 -> ACK t+1 -> RVAL t+2 -> SDVAL t+3.
- Return-valid outputs are 0 on every cycle without a beat. Data outputs hold their last value.

Decomposition:
- Shared package lmi_cbus_pkg holds:
  - state enum ARB_IDLE/ARB_REQ/ARB_RDATA
  - grant-class constants GNT_I/GNT_DR/GNT_WB
  - default LINE_WORDS
- Sub-module lmi_cbus_arb_slot: one capture register (valid, addr, attributes, data) with load/clear/overflow. Instantiate it three times.

Test Plan:
- Reset mid-burst: assert reset during beat 2 of a 4-beat I fill -> all outputs 0, CBUS_SWBEMPTY=1; later stray MEM_RVAL produces no CBUS_SIVAL.
- Simultaneous requests: IREQ (IUC=0, 0x1000_0004) and DREQ read (DLINE=0, 0x2000_0008) at t, ACK immediate -> D granted first (MEM_ADDR 0x2000_0008, BURST=0); after its beat, I granted (MEM_ADDR 0x1000_0004, BURST=1); 4 SIVAL pulses with RDATA 0xA0..0xA3 in order.
- Write-then-read ordering: DREQ write (0x3000_0000, BE=4'b0011, DO=0xDEADBEEF) then DREQ read at t+1, ACK delayed 3 cycles -> SWBEMPTY=0 from t+1; write issued first with MEM_WDATA=0xDEADBEEF, MEM_BE=0011; read MEM_REQ only after the write ACK; SWBEMPTY=1 the cycle after that ACK.
- Round-robin fairness: continuous D reads plus pending I -> grants alternate D,I,D,I over 4 transactions.
- Overflow: second IREQ while I_PEND set -> ARB_OVF=1 and stays 1; first request completes normally; second is never issued.
- MEM_REQ hold: ACK withheld 5 cycles -> MEM_REQ and all MEM_* fields stable across all 5 cycles.

Source files
------------

// File: rtl/lmi_cbus_pkg.sv
// Shared types and constants for the cache-bus to memory-port arbiter.
package lmi_cbus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_REQ   = 2'd1,
    ARB_RDATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_I  = 2'd0;
  localparam logic [1:0] GNT_DR = 2'd1;
  localparam logic [1:0] GNT_WB = 2'd2;

  localparam int LMI_LINE_WORDS = 4;

  // Everything a captured request needs to drive the memory port.
  typedef struct packed {
    logic [31:0] addr;
    logic        burst;
    logic [3:0]  be;
    logic [31:0] data;
  } slot_t;

endpackage

// File: rtl/lmi_cbus_arb_slot.sv
// One request capture register: loads when empty, flags a load attempt
// against an occupied slot, clears when its transaction retires.
module lmi_cbus_arb_slot
  import lmi_cbus_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  clr,
  input  slot_t ld,
  output logic  valid,
  output slot_t q,
  output logic  ovf
);

  logic  valid_q, valid_d;
  slot_t q_q, q_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    q_d     = q_q;
    if (clr) begin
      valid_d = 1'b0;
    end
    if (load && !valid_q) begin
      valid_d = 1'b1;
      q_d     = ld;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops
  // update together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      q_q     <= '0;
    end else begin
      valid_q <= valid_d;
      q_q     <= q_d;
    end
  end

  assign valid = valid_q;
  assign q     = q_q;
  assign ovf   = load && valid_q;

endmodule

// File: rtl/lmi_cbus_arb.sv
// Arbitrates instruction and data cache-bus requests onto one memory port,
// with a 1-entry posted write buffer and single/line-fill read sequencing.
module lmi_cbus_arb
  import lmi_cbus_pkg::*;
#(
  parameter int LINE_WORDS = LMI_LINE_WORDS,
  parameter int BCNT_W     = 3
) (
  input  logic        IDCLOCKI,
  input  logic        RESET_D2_R_N,
  input  logic        CBUS_IREQ,
  input  logic [31:0] CBUS_IADDR,
  input  logic        CBUS_IUC,
  input  logic        CBUS_DREQ,
  input  logic [31:0] CBUS_DADDR,
  input  logic        CBUS_DRW,
  input  logic        CBUS_DLINE,
  input  logic [3:0]  CBUS_DBE,
  input  logic [31:0] CBUS_DO,
  output logic        CBUS_SIVAL,
  output logic [31:0] CBUS_SIDATA,
  output logic        CBUS_SDVAL,
  output logic [31:0] CBUS_SDDATA,
  output logic        CBUS_SWBEMPTY,
  output logic        ARB_OVF,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  output logic        MEM_WR,
  output logic        MEM_BURST,
  output logic [3:0]  MEM_BE,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic        MEM_RVAL,
  input  logic [31:0] MEM_RDATA
);

  localparam logic [BCNT_W-1:0] LAST_BURST_BEAT = BCNT_W'(LINE_WORDS - 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              last_d_q, last_d_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              ovf_q, ovf_d;
  logic              si_val_q, si_val_d;
  logic              sd_val_q, sd_val_d;
  logic [31:0]       si_data_q, si_data_d;
  logic [31:0]       sd_data_q, sd_data_d;

  slot_t i_ld, dr_ld, wb_ld;
  slot_t i_q, dr_q, wb_q, sel;
  logic  i_v, dr_v, wb_v;
  logic  i_ovf, dr_ovf, wb_ovf;
  logic  i_clr, dr_clr, wb_clr;

  // Reads are word-aligned and always fetch all four bytes.
  assign i_ld  = '{addr: {CBUS_IADDR[31:2], 2'b00}, burst: !CBUS_IUC,
                   be: 4'hF, data: 32'h0};
  assign dr_ld = '{addr: {CBUS_DADDR[31:2], 2'b00}, burst: CBUS_DLINE,
                   be: 4'hF, data: 32'h0};
  assign wb_ld = '{addr: CBUS_DADDR, burst: 1'b0, be: CBUS_DBE, data: CBUS_DO};

  lmi_cbus_arb_slot u_i_slot (
    .clk   (IDCLOCKI),
    .rst_n (RESET_D2_R_N),
    .load  (CBUS_IREQ),
    .clr   (i_clr),
    .ld    (i_ld),
    .valid (i_v),
    .q     (i_q),
    .ovf   (i_ovf)
  );

  lmi_cbus_arb_slot u_dr_slot (
    .clk   (IDCLOCKI),
    .rst_n (RESET_D2_R_N),
    .load  (CBUS_DREQ && !CBUS_DRW),
    .clr   (dr_clr),
    .ld    (dr_ld),
    .valid (dr_v),
    .q     (dr_q),
    .ovf   (dr_ovf)
  );

  lmi_cbus_arb_slot u_wb_slot (
    .clk   (IDCLOCKI),
    .rst_n (RESET_D2_R_N),
    .load  (CBUS_DREQ && CBUS_DRW),
    .clr   (wb_clr),
    .ld    (wb_ld),
    .valid (wb_v),
    .q     (wb_q),
    .ovf   (wb_ovf)
  );

  // A pending write hides the data read, so reads never pass the write.
  logic       d_avail, arb_any, issuing;
  logic [1:0] d_gnt, arb_gnt, cur_gnt;

  assign d_avail = wb_v || dr_v;
  assign d_gnt   = wb_v ? GNT_WB : GNT_DR;
  assign arb_any = i_v || d_avail;
  assign arb_gnt = (d_avail && (!i_v || !last_d_q)) ? d_gnt : GNT_I;

  // The grant cycle in IDLE already drives the request, which gives the
  // one-cycle capture-to-request latency.
  assign issuing = (state_q == ARB_REQ) || ((state_q == ARB_IDLE) && arb_any);
  assign cur_gnt = (state_q == ARB_IDLE) ? arb_gnt : gnt_q;

  always_comb begin
    case (cur_gnt)
      GNT_DR:  sel = dr_q;
      GNT_WB:  sel = wb_q;
      default: sel = i_q;
    endcase
  end

  assign MEM_REQ   = issuing;
  assign MEM_ADDR  = issuing ? sel.addr : 32'h0;
  assign MEM_WR    = issuing && (cur_gnt == GNT_WB);
  assign MEM_BURST = issuing && sel.burst;
  assign MEM_BE    = issuing ? sel.be : 4'h0;
  assign MEM_WDATA = issuing ? sel.data : 32'h0;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d_d  = last_d_q;
    bcnt_d    = bcnt_q;
    ovf_d     = ovf_q || i_ovf || dr_ovf || wb_ovf;
    si_val_d  = 1'b0;
    sd_val_d  = 1'b0;
    si_data_d = si_data_q;
    sd_data_d = sd_data_q;
    i_clr     = 1'b0;
    dr_clr    = 1'b0;
    wb_clr    = 1'b0;

    case (state_q)
      ARB_IDLE, ARB_REQ: begin
        if (issuing) begin
          gnt_d  = cur_gnt;
          bcnt_d = '0;
          if (state_q == ARB_IDLE) begin
            last_d_d = (cur_gnt != GNT_I);
          end
          if (!MEM_ACK) begin
            state_d = ARB_REQ;
          end else if (cur_gnt == GNT_WB) begin
            wb_clr  = 1'b1;
            state_d = ARB_IDLE;
          end else begin
            state_d = ARB_RDATA;
          end
        end
      end

      ARB_RDATA: begin
        if (MEM_RVAL) begin
          if (gnt_q == GNT_I) begin
            si_val_d  = 1'b1;
            si_data_d = MEM_RDATA;
          end else begin
            sd_val_d  = 1'b1;
            sd_data_d = MEM_RDATA;
          end
          if (bcnt_q == (sel.burst ? LAST_BURST_BEAT : '0)) begin
            i_clr   = (gnt_q == GNT_I);
            dr_clr  = (gnt_q != GNT_I);
            state_d = ARB_IDLE;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge IDCLOCKI or negedge RESET_D2_R_N) begin
    if (!RESET_D2_R_N) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= GNT_I;
      last_d_q  <= 1'b0;
      bcnt_q    <= '0;
      ovf_q     <= 1'b0;
      si_val_q  <= 1'b0;
      sd_val_q  <= 1'b0;
      si_data_q <= 32'h0;
      sd_data_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_d_q  <= last_d_d;
      bcnt_q    <= bcnt_d;
      ovf_q     <= ovf_d;
      si_val_q  <= si_val_d;
      sd_val_q  <= sd_val_d;
      si_data_q <= si_data_d;
      sd_data_q <= sd_data_d;
    end
  end

  assign CBUS_SIVAL    = si_val_q;
  assign CBUS_SIDATA   = si_data_q;
  assign CBUS_SDVAL    = sd_val_q;
  assign CBUS_SDDATA   = sd_data_q;
  assign CBUS_SWBEMPTY = !wb_v;
  assign ARB_OVF       = ovf_q;

endmodule

// File: tb/tb_lmi_cbus_arb.sv
// Directed bench for lmi_cbus_arb: a table of single-word transactions plus
// hand-written sequences for ordering, fairness, overflow, hold and reset.
module tb_lmi_cbus_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CBUS_IREQ, CBUS_IUC, CBUS_DREQ, CBUS_DRW, CBUS_DLINE;
  logic [31:0] CBUS_IADDR, CBUS_DADDR, CBUS_DO;
  logic [3:0]  CBUS_DBE;
  logic        CBUS_SIVAL, CBUS_SDVAL, CBUS_SWBEMPTY, ARB_OVF;
  logic [31:0] CBUS_SIDATA, CBUS_SDDATA;
  logic        MEM_REQ, MEM_WR, MEM_BURST, MEM_ACK, MEM_RVAL;
  logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic [3:0]  MEM_BE;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lmi_cbus_arb #(.LINE_WORDS(4), .BCNT_W(3)) dut (
    .IDCLOCKI      (clk),
    .RESET_D2_R_N  (rst_n),
    .CBUS_IREQ     (CBUS_IREQ),
    .CBUS_IADDR    (CBUS_IADDR),
    .CBUS_IUC      (CBUS_IUC),
    .CBUS_DREQ     (CBUS_DREQ),
    .CBUS_DADDR    (CBUS_DADDR),
    .CBUS_DRW      (CBUS_DRW),
    .CBUS_DLINE    (CBUS_DLINE),
    .CBUS_DBE      (CBUS_DBE),
    .CBUS_DO       (CBUS_DO),
    .CBUS_SIVAL    (CBUS_SIVAL),
    .CBUS_SIDATA   (CBUS_SIDATA),
    .CBUS_SDVAL    (CBUS_SDVAL),
    .CBUS_SDDATA   (CBUS_SDDATA),
    .CBUS_SWBEMPTY (CBUS_SWBEMPTY),
    .ARB_OVF       (ARB_OVF),
    .MEM_REQ       (MEM_REQ),
    .MEM_ADDR      (MEM_ADDR),
    .MEM_WR        (MEM_WR),
    .MEM_BURST     (MEM_BURST),
    .MEM_BE        (MEM_BE),
    .MEM_WDATA     (MEM_WDATA),
    .MEM_ACK       (MEM_ACK),
    .MEM_RVAL      (MEM_RVAL),
    .MEM_RDATA     (MEM_RDATA)
  );

  typedef enum int {K_IFETCH, K_DREAD, K_DWRITE} kind_e;

  typedef struct {
    kind_e       kind;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic        exp_wr;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs[6];
  vec_t v;
  int   exp_top[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    CBUS_IREQ = 1'b0; CBUS_IADDR = 32'h0; CBUS_IUC = 1'b0;
    CBUS_DREQ = 1'b0; CBUS_DADDR = 32'h0; CBUS_DRW = 1'b0;
    CBUS_DLINE = 1'b0; CBUS_DBE = 4'h0; CBUS_DO = 32'h0;
    MEM_ACK = 1'b0; MEM_RVAL = 1'b0; MEM_RDATA = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!MEM_REQ && n < 20) begin
      step();
      n++;
    end
    check({name, " req"}, MEM_REQ, 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " sival"}, CBUS_SIVAL, 0);
    check({name, " sidata"}, CBUS_SIDATA, 0);
    check({name, " sdval"}, CBUS_SDVAL, 0);
    check({name, " sddata"}, CBUS_SDDATA, 0);
    check({name, " swbempty"}, CBUS_SWBEMPTY, 1);
    check({name, " ovf"}, ARB_OVF, 0);
    check({name, " mem_req"}, MEM_REQ, 0);
    check({name, " mem_addr"}, MEM_ADDR, 0);
    check({name, " mem_ctl"}, {MEM_WR, MEM_BURST, MEM_BE}, 0);
    check({name, " mem_wdata"}, MEM_WDATA, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{K_IFETCH, 32'h1000_0007, 4'h0, 32'h0,         32'h1111_2222, 32'h1000_0004, 1'b0, 4'hF};
    vecs[1] = '{K_DREAD,  32'h2000_000B, 4'h0, 32'h0,         32'h3333_4444, 32'h2000_0008, 1'b0, 4'hF};
    vecs[2] = '{K_DWRITE, 32'h3000_0003, 4'h8, 32'hCAFE_F00D, 32'h0,         32'h3000_0003, 1'b1, 4'h8};
    vecs[3] = '{K_DWRITE, 32'h4000_0010, 4'hF, 32'h1234_5678, 32'h0,         32'h4000_0010, 1'b1, 4'hF};
    vecs[4] = '{K_IFETCH, 32'hFFFF_FFFE, 4'h0, 32'h0,         32'hFFFF_0000, 32'hFFFF_FFFC, 1'b0, 4'hF};
    vecs[5] = '{K_DREAD,  32'h0000_0001, 4'h0, 32'h0,         32'h5A5A_5A5A, 32'h0000_0000, 1'b0, 4'hF};
    exp_top = '{2, 1, 2, 1};

    do_reset();
    check_reset_outputs("reset");

    // Table of single-word transactions, idle bus, immediate ACK.
    for (int k = 0; k < 6; k++) begin
      v = vecs[k];
      case (v.kind)
        K_IFETCH: begin
          CBUS_IREQ = 1'b1; CBUS_IADDR = v.addr; CBUS_IUC = 1'b1;
        end
        K_DREAD: begin
          CBUS_DREQ = 1'b1; CBUS_DADDR = v.addr; CBUS_DRW = 1'b0; CBUS_DLINE = 1'b0;
        end
        default: begin
          CBUS_DREQ = 1'b1; CBUS_DADDR = v.addr; CBUS_DRW = 1'b1;
          CBUS_DBE = v.be; CBUS_DO = v.wdata;
        end
      endcase
      step();
      CBUS_IREQ = 1'b0;
      CBUS_DREQ = 1'b0;
      wait_req($sformatf("v%0d", k));
      check($sformatf("v%0d addr", k), MEM_ADDR, v.exp_addr);
      check($sformatf("v%0d wr", k), MEM_WR, v.exp_wr);
      check($sformatf("v%0d be", k), MEM_BE, v.exp_be);
      check($sformatf("v%0d burst", k), MEM_BURST, 0);
      if (v.kind == K_DWRITE) begin
        check($sformatf("v%0d wdata", k), MEM_WDATA, v.wdata);
        check($sformatf("v%0d wb busy", k), CBUS_SWBEMPTY, 0);
      end
      MEM_ACK = 1'b1;
      step();
      MEM_ACK = 1'b0;
      if (v.kind == K_DWRITE) begin
        check($sformatf("v%0d wb empty", k), CBUS_SWBEMPTY, 1);
        check($sformatf("v%0d idle", k), MEM_REQ, 0);
      end else begin
        MEM_RVAL = 1'b1;
        MEM_RDATA = v.rdata;
        step();
        MEM_RVAL = 1'b0;
        if (v.kind == K_IFETCH) begin
          check($sformatf("v%0d sival", k), {CBUS_SIVAL, CBUS_SDVAL}, 2'b10);
          check($sformatf("v%0d sidata", k), CBUS_SIDATA, v.rdata);
        end else begin
          check($sformatf("v%0d sdval", k), {CBUS_SIVAL, CBUS_SDVAL}, 2'b01);
          check($sformatf("v%0d sddata", k), CBUS_SDDATA, v.rdata);
        end
      end
      step();
    end

    // Simultaneous I line fill and D single read: D first, then I burst.
    do_reset();
    CBUS_IREQ = 1'b1; CBUS_IADDR = 32'h1000_0004; CBUS_IUC = 1'b0;
    CBUS_DREQ = 1'b1; CBUS_DADDR = 32'h2000_0008; CBUS_DRW = 1'b0; CBUS_DLINE = 1'b0;
    step();
    CBUS_IREQ = 1'b0; CBUS_DREQ = 1'b0;
    check("sim d req", MEM_REQ, 1);
    check("sim d addr", MEM_ADDR, 32'h2000_0008);
    check("sim d burst", MEM_BURST, 0);
    MEM_ACK = 1'b1;
    step();
    MEM_ACK = 1'b0;
    MEM_RVAL = 1'b1; MEM_RDATA = 32'h55;
    step();
    MEM_RVAL = 1'b0;
    check("sim sdval", CBUS_SDVAL, 1);
    check("sim sddata", CBUS_SDDATA, 32'h55);
    check("sim no sival", CBUS_SIVAL, 0);
    check("sim i req", MEM_REQ, 1);
    check("sim i addr", MEM_ADDR, 32'h1000_0004);
    check("sim i burst", MEM_BURST, 1);
    MEM_ACK = 1'b1;
    step();
    MEM_ACK = 1'b0;
    for (int k = 0; k < 4; k++) begin
      MEM_RVAL = 1'b1;
      MEM_RDATA = 32'hA0 + k;
      step();
      check($sformatf("sim beat%0d sival", k), CBUS_SIVAL, 1);
      check($sformatf("sim beat%0d sidata", k), CBUS_SIDATA, 32'hA0 + k);
    end
    MEM_RVAL = 1'b0;
    check("sim done req", MEM_REQ, 0);
    step();
    check("sim sival low", CBUS_SIVAL, 0);
    check("sim sidata hold", CBUS_SIDATA, 32'hA3);

    // Write followed by a read, ACK delayed three cycles.
    do_reset();
    CBUS_DREQ = 1'b1; CBUS_DADDR = 32'h3000_0000; CBUS_DRW = 1'b1;
    CBUS_DBE = 4'b0011; CBUS_DO = 32'hDEAD_BEEF;
    step();
    CBUS_DRW = 1'b0; CBUS_DLINE = 1'b0;
    check("raw swbempty", CBUS_SWBEMPTY, 0);
    check("raw w req", MEM_REQ, 1);
    check("raw w wr", MEM_WR, 1);
    check("raw w addr", MEM_ADDR, 32'h3000_0000);
    check("raw w be", MEM_BE, 4'b0011);
    check("raw w wdata", MEM_WDATA, 32'hDEAD_BEEF);
    step();
    CBUS_DREQ = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("raw wait%0d wr", c), {MEM_REQ, MEM_WR}, 2'b11);
      check($sformatf("raw wait%0d swbempty", c), CBUS_SWBEMPTY, 0);
      if (c == 2) MEM_ACK = 1'b1;
      step();
    end
    MEM_ACK = 1'b0;
    check("raw swbempty after ack", CBUS_SWBEMPTY, 1);
    check("raw r req", {MEM_REQ, MEM_WR}, 2'b10);
    check("raw r addr", MEM_ADDR, 32'h3000_0000);
    check("raw r be", MEM_BE, 4'hF);
    MEM_ACK = 1'b1;
    step();
    MEM_ACK = 1'b0;
    MEM_RVAL = 1'b1; MEM_RDATA = 32'h7777_0001;
    step();
    MEM_RVAL = 1'b0;
    check("raw sddata", {31'h0, CBUS_SDVAL} ^ CBUS_SDDATA, 32'h7777_0000);
    check("raw ovf", ARB_OVF, 0);

    // MEM_REQ hold: ACK withheld five cycles.
    do_reset();
    CBUS_DREQ = 1'b1; CBUS_DADDR = 32'h5000_0001; CBUS_DRW = 1'b1;
    CBUS_DBE = 4'b0101; CBUS_DO = 32'h0BAD_F00D;
    step();
    CBUS_DREQ = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d ctl", c), {MEM_REQ, MEM_WR, MEM_BURST, MEM_BE}, 7'b110_0101);
      check($sformatf("hold%0d addr", c), MEM_ADDR, 32'h5000_0001);
      check($sformatf("hold%0d wdata", c), MEM_WDATA, 32'h0BAD_F00D);
      step();
    end
    MEM_ACK = 1'b1;
    step();
    MEM_ACK = 1'b0;
    check("hold swbempty", CBUS_SWBEMPTY, 1);

    // Round-robin: D reads kept continuously pending against pending I.
    do_reset();
    CBUS_IREQ = 1'b1; CBUS_IADDR = 32'h1000_0000; CBUS_IUC = 1'b1;
    CBUS_DREQ = 1'b1; CBUS_DADDR = 32'h2000_0000; CBUS_DRW = 1'b0; CBUS_DLINE = 1'b0;
    step();
    CBUS_IREQ = 1'b0; CBUS_DREQ = 1'b0;
    for (int n = 0; n < 4; n++) begin
      logic got_d;
      wait_req($sformatf("rr%0d", n));
      check($sformatf("rr%0d grant", n), {28'h0, MEM_ADDR[31:28]}, exp_top[n]);
      got_d = (MEM_ADDR[31:28] == 4'h2);
      MEM_ACK = 1'b1;
      step();
      MEM_ACK = 1'b0;
      MEM_RVAL = 1'b1; MEM_RDATA = 32'h0 + n;
      step();
      MEM_RVAL = 1'b0;
      if (got_d) CBUS_DREQ = 1'b1;
      else CBUS_IREQ = 1'b1;
      step();
      CBUS_IREQ = 1'b0; CBUS_DREQ = 1'b0;
    end
    check("rr ovf", ARB_OVF, 0);

    // Overflow: second IREQ while the first is still pending.
    do_reset();
    CBUS_IREQ = 1'b1; CBUS_IADDR = 32'h6000_0000; CBUS_IUC = 1'b1;
    step();
    check("ovf first req", MEM_REQ, 1);
    check("ovf first addr", MEM_ADDR, 32'h6000_0000);
    check("ovf clear", ARB_OVF, 0);
    CBUS_IADDR = 32'h7000_0000;
    step();
    CBUS_IREQ = 1'b0;
    check("ovf set", ARB_OVF, 1);
    check("ovf addr stable", MEM_ADDR, 32'h6000_0000);
    MEM_ACK = 1'b1;
    step();
    MEM_ACK = 1'b0;
    MEM_RVAL = 1'b1; MEM_RDATA = 32'h66;
    step();
    MEM_RVAL = 1'b0;
    check("ovf sival", CBUS_SIVAL, 1);
    check("ovf sidata", CBUS_SIDATA, 32'h66);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("ovf no reissue%0d", c), MEM_REQ, 0);
      step();
    end
    check("ovf sticky", ARB_OVF, 1);

    // Reset during beat 2 of a 4-beat I fill, then stray beats.
    do_reset();
    CBUS_IREQ = 1'b1; CBUS_IADDR = 32'h8000_0000; CBUS_IUC = 1'b0;
    step();
    CBUS_IREQ = 1'b0;
    check("rst burst", MEM_BURST, 1);
    MEM_ACK = 1'b1;
    step();
    MEM_ACK = 1'b0;
    for (int k = 0; k < 2; k++) begin
      MEM_RVAL = 1'b1; MEM_RDATA = 32'hB0 + k;
      step();
    end
    check("rst beat1 sidata", CBUS_SIDATA, 32'hB1);
    MEM_RDATA = 32'hB2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    step();
    rst_n = 1'b1;
    step();
    check("stray sival0", CBUS_SIVAL, 0);
    check("stray req0", MEM_REQ, 0);
    step();
    check("stray sival1", CBUS_SIVAL, 0);
    check("stray sidata", CBUS_SIDATA, 0);
    MEM_RVAL = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
